// File: rtl/dmem_ctrl.sv
// Data-memory controller: fixed-latency LSU access to a word SRAM with lane stores and extended loads.
// Optional macro DMEM_ACCESS_FAULT_EN adds fault_o and drops aligned out-of-range requests.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wr_data_i,
    input  logic        dmem_write_i,
    input  logic        dmem_read_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] dmem_rd_data_o,
    output logic        stall_o,
    output logic        misaligned_o
`ifdef DMEM_ACCESS_FAULT_EN
    ,
    output logic        fault_o
`endif
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      lane_q, lane_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [2:0]      f3_q, f3_d;
    logic            store_q, store_d;
    logic            inr_q, inr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req_c, size_ok_c, align_bad_c, in_range_c, drop_oor_c, accept_c;
    logic            stall_c, rd_en_c, wr_en_c;
    logic [31:0]     wofs_c;
    logic [AW-1:0]   rd_idx_c;
    logic [3:0]      be_c;
    logic [31:0]     wrep_c, merged_c, ext_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;

    // Request decode: size legality, alignment and array range
    assign req_c  = dmem_read_i | dmem_write_i;
    assign wofs_c = (dmem_addr_i - BASE_ADDR) >> 2;
    assign in_range_c = (dmem_addr_i >= BASE_ADDR) && (wofs_c < DEPTH_WORDS);

    always_comb begin
        size_ok_c = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: size_ok_c = 1'b1;
            3'b100, 3'b101:         size_ok_c = ~dmem_write_i;
            default:                size_ok_c = 1'b0;
        endcase
    end

    assign align_bad_c = ((funct3_i[1:0] == 2'b01) & dmem_addr_i[0]) |
                         ((funct3_i[1:0] == 2'b10) & (|dmem_addr_i[1:0]));

    assign misaligned_o = (state_q == IDLE) & req_c & (~size_ok_c | align_bad_c) & ~rst_i;

`ifdef DMEM_ACCESS_FAULT_EN
    assign drop_oor_c = (state_q == IDLE) & req_c & ~misaligned_o & ~in_range_c & ~rst_i;
    assign fault_o    = drop_oor_c;
`else
    assign drop_oor_c = 1'b0;
`endif

    assign accept_c = (state_q == IDLE) & req_c & ~misaligned_o & ~drop_oor_c & ~rst_i;

    // Next-state and request capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        idx_d    = idx_q;
        f3_d     = f3_q;
        store_d  = store_q;
        inr_d    = inr_q;
        wdata_d  = wdata_q;
        stall_c  = 1'b0;
        rd_en_c  = 1'b0;
        rd_idx_c = idx_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    stall_c  = 1'b1;
                    lane_d   = dmem_addr_i[1:0];
                    idx_d    = AW'(wofs_c);
                    f3_d     = funct3_i;
                    store_d  = dmem_write_i;
                    inr_d    = in_range_c;
                    wdata_d  = dmem_wr_data_i;
                    cnt_d    = CW'(WAIT_CYCLES);
                    rd_en_c  = in_range_c;
                    rd_idx_c = AW'(wofs_c);
                    state_d  = (WAIT_CYCLES != 0) ? BUSY : RESP;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    rd_en_c = inr_q & ~rst_i;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            idx_q   <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            inr_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            idx_q   <= idx_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            inr_q   <= inr_d;
            wdata_q <= wdata_d;
        end
    end

    // Store merge: replicate the narrow datum and enable only the addressed lanes
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be_c   = 4'b0001 << lane_q;
                wrep_c = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_c   = lane_q[1] ? 4'b1100 : 4'b0011;
                wrep_c = {2{wdata_q[15:0]}};
            end
            default: begin
                be_c   = 4'b1111;
                wrep_c = wdata_q;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_c[8*i +: 8] = be_c[i] ? wrep_c[8*i +: 8] : rdata_q[8*i +: 8];
        end
    end

    // A store commits only on the edge leaving RESP, so a reset there cancels it
    assign wr_en_c = (state_q == RESP) & store_q & inr_q & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem_q[idx_q] <= merged_c;
        end
        if (rd_en_c) begin
            rdata_q <= mem_q[rd_idx_c];
        end
    end

    // Load lane select and extension
    always_comb begin
        byte_c = 8'(rdata_q >> {lane_q, 3'b000});
        half_c = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  ext_c = {24'h0, byte_c};
            3'b001:  ext_c = {{16{half_c[15]}}, half_c};
            3'b101:  ext_c = {16'h0, half_c};
            default: ext_c = rdata_q;
        endcase
    end

    assign dmem_rd_data_o = ((state_q == RESP) & ~store_q & inr_q & ~rst_i) ? ext_c : 32'h0;
    assign stall_o        = stall_c & ~rst_i;

endmodule
